// File: rtl/pipeline_operand_stage.sv
// Operand-fetch stage: resolves rs1/rs2 through a priority forwarding network,
// then holds the results in a main entry and one skid entry toward EX.
//
// Ports:
//   clk, reset (async, active-low), flush (sync kill of held entries)
//   in_*       : upstream entry with valid/ready handshake
//   rf_rdata*  : register-file read data for in_rs1/in_rs2
//   fwd_*      : NFWD forwarding sources, index 0 is the youngest producer
//   out_*      : resolved entry toward EX with valid/ready handshake
//   hazard     : combinational stall when a selected source is still pending
//   stall_cnt  : saturating count of cycles in_valid was held off
module pipeline_operand_stage #(
  parameter int XLEN   = 64,
  parameter int NFWD   = 3,
  parameter int CTRL_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        in_imm,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [4:0]             in_rd,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [XLEN-1:0]        rf_rdata1,
  input  logic [XLEN-1:0]        rf_rdata2,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD-1:0]        fwd_pending,
  input  logic [NFWD*5-1:0]      fwd_rd,
  input  logic [NFWD*XLEN-1:0]   fwd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_imm,
  output logic [XLEN-1:0]        out_rs1_data,
  output logic [XLEN-1:0]        out_rs2_data,
  output logic [4:0]             out_rd,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic                   hazard,
  output logic [31:0]            stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t      main_q, main_d;
  entry_t      skid_q, skid_d;
  entry_t      new_e;
  logic        main_valid_q, main_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            rs1_pend, rs2_pend;
  logic            accept, pop;
  logic            mv_skid, ld_main, ld_skid, drain;

  // Walk from lowest priority upward so the youngest match overwrites.
  // A pending flag is taken only from the source that actually wins.
  always_comb begin
    rs1_val  = rf_rdata1;
    rs1_pend = 1'b0;
    rs2_val  = rf_rdata2;
    rs2_pend = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_rd[i*5 +: 5] == in_rs1) begin
        rs1_val  = fwd_data[i*XLEN +: XLEN];
        rs1_pend = fwd_pending[i];
      end
      if (fwd_valid[i] && fwd_rd[i*5 +: 5] == in_rs2) begin
        rs2_val  = fwd_data[i*XLEN +: XLEN];
        rs2_pend = fwd_pending[i];
      end
    end
    if (in_rs1 == 5'd0) begin
      rs1_val  = '0;
      rs1_pend = 1'b0;
    end
    if (in_rs2 == 5'd0) begin
      rs2_val  = '0;
      rs2_pend = 1'b0;
    end
  end

  always_comb begin
    new_e      = '0;
    new_e.pc   = in_pc;
    new_e.imm  = in_imm;
    new_e.rs1  = rs1_val;
    new_e.rs2  = rs2_val;
    new_e.rd   = in_rd;
    new_e.ctrl = in_ctrl;
  end

  assign hazard   = in_valid & (rs1_pend | rs2_pend);
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~hazard & ~flush;
  assign pop      = main_valid_q & out_ready;

  // Mutually exclusive storage moves; flush overrides every one of them.
  assign mv_skid = ~flush & pop & skid_valid_q;
  assign ld_main = accept & (~main_valid_q | (pop & ~skid_valid_q));
  assign ld_skid = accept & main_valid_q & ~pop;
  assign drain   = ~flush & pop & ~skid_valid_q & ~accept;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    unique case (1'b1)
      flush: begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
      mv_skid: begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end
      ld_main: begin
        main_d       = new_e;
        main_valid_d = 1'b1;
      end
      ld_skid: begin
        skid_d       = new_e;
        skid_valid_d = 1'b1;
      end
      drain: begin
        main_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !accept && !flush && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_pc       = main_q.pc;
  assign out_imm      = main_q.imm;
  assign out_rs1_data = main_q.rs1;
  assign out_rs2_data = main_q.rs2;
  assign out_rd       = main_q.rd;
  assign out_ctrl     = main_q.ctrl;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_operand_stage.sv
// Directed bench for pipeline_operand_stage: forwarding priority, x0,
// hazard stall, skid ordering, flush, mid-run reset and counter saturation.
module tb_pipeline_operand_stage;
  localparam int XLEN   = 64;
  localparam int NFWD   = 3;
  localparam int CTRL_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, flush, in_valid, in_ready;
  logic [XLEN-1:0]      in_pc, in_imm, rf_rdata1, rf_rdata2;
  logic [4:0]           in_rs1, in_rs2, in_rd;
  logic [CTRL_W-1:0]    in_ctrl;
  logic [NFWD-1:0]      fwd_valid, fwd_pending;
  logic [NFWD*5-1:0]    fwd_rd;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 out_valid, out_ready, hazard;
  logic [XLEN-1:0]      out_pc, out_imm, out_rs1_data, out_rs2_data;
  logic [4:0]           out_rd;
  logic [CTRL_W-1:0]    out_ctrl;
  logic [31:0]          stall_cnt;

  int total = 0;
  int bad   = 0;

  pipeline_operand_stage #(
    .XLEN(XLEN), .NFWD(NFWD), .CTRL_W(CTRL_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_ctrl(in_ctrl),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_ctrl(out_ctrl),
    .hazard(hazard), .stall_cnt(stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    flush       = 1'b0;
    in_pc       = '0;
    in_imm      = '0;
    in_rs1      = '0;
    in_rs2      = '0;
    in_rd       = '0;
    in_ctrl     = '0;
    rf_rdata1   = '0;
    rf_rdata2   = '0;
    fwd_valid   = '0;
    fwd_pending = '0;
    fwd_rd      = '0;
    fwd_data    = '0;
  endtask

  // imm and ctrl are derived from pc so each entry is self-identifying.
  task automatic put(input logic [XLEN-1:0] pc, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [4:0] rd,
                     input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2);
    in_valid  = 1'b1;
    in_pc     = pc;
    in_imm    = pc + 64'h4;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_rd     = rd;
    in_ctrl   = {16'hC0DE, pc[15:0]};
    rf_rdata1 = r1;
    rf_rdata2 = r2;
  endtask

  task automatic test_reset();
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    total++; if (out_pc !== 64'h0) begin bad++; $display("FAIL rst_out_pc got=%0h exp=0", out_pc); end
    total++; if (out_ctrl !== 32'h0) begin bad++; $display("FAIL rst_out_ctrl got=%0h exp=0", out_ctrl); end
    total++; if (stall_cnt !== 32'h0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", stall_cnt); end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_fwd_priority();
    put(64'h100, 5'd5, 5'd3, 5'd9, 64'h11, 64'h22);
    fwd_valid = 3'b011;
    fwd_rd    = {5'd0, 5'd5, 5'd5};
    fwd_data  = {64'h0, 64'hBB, 64'hAA};
    #1;
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL fwd_hazard got=%0h exp=0", hazard); end
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fwd0_valid got=%0h exp=1", out_valid); end
    total++; if (out_rs1_data !== 64'hAA) begin bad++; $display("FAIL fwd0_rs1 got=%0h exp=aa", out_rs1_data); end
    total++; if (out_rs2_data !== 64'h22) begin bad++; $display("FAIL fwd0_rs2 got=%0h exp=22", out_rs2_data); end
    total++; if (out_imm !== 64'h104) begin bad++; $display("FAIL fwd0_imm got=%0h exp=104", out_imm); end
    total++; if (out_rd !== 5'd9) begin bad++; $display("FAIL fwd0_rd got=%0h exp=9", out_rd); end
    total++; if (out_ctrl !== 32'hC0DE0100) begin bad++; $display("FAIL fwd0_ctrl got=%0h exp=c0de0100", out_ctrl); end
    put(64'h200, 5'd5, 5'd6, 5'd1, 64'h11, 64'h66);
    fwd_valid = 3'b110;
    fwd_rd    = {5'd6, 5'd5, 5'd5};
    fwd_data  = {64'hCC, 64'hBB, 64'hAA};
    step();
    total++; if (out_rs1_data !== 64'hBB) begin bad++; $display("FAIL fwd1_rs1 got=%0h exp=bb", out_rs1_data); end
    total++; if (out_rs2_data !== 64'hCC) begin bad++; $display("FAIL fwd2_rs2 got=%0h exp=cc", out_rs2_data); end
    put(64'h300, 5'd5, 5'd6, 5'd1, 64'h11, 64'h66);
    fwd_valid = 3'b101;
    fwd_rd    = {5'd7, 5'd5, 5'd4};
    step();
    total++; if (out_rs1_data !== 64'h11) begin bad++; $display("FAIL fwd_rf1 got=%0h exp=11", out_rs1_data); end
    total++; if (out_rs2_data !== 64'h66) begin bad++; $display("FAIL fwd_rf2 got=%0h exp=66", out_rs2_data); end
    idle();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fwd_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_x0();
    put(64'h400, 5'd0, 5'd0, 5'd2, 64'h44, 64'h33);
    fwd_valid   = 3'b001;
    fwd_pending = 3'b001;
    fwd_rd      = {5'd0, 5'd0, 5'd0};
    fwd_data    = {64'h0, 64'h0, 64'hFF};
    #1;
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL x0_hazard got=%0h exp=0", hazard); end
    step();
    idle();
    total++; if (out_rs2_data !== 64'h0) begin bad++; $display("FAIL x0_rs2 got=%0h exp=0", out_rs2_data); end
    total++; if (out_rs1_data !== 64'h0) begin bad++; $display("FAIL x0_rs1 got=%0h exp=0", out_rs1_data); end
    step();
  endtask

  task automatic test_hazard();
    put(64'h500, 5'd7, 5'd1, 5'd3, 64'h70, 64'h10);
    fwd_valid   = 3'b011;
    fwd_pending = 3'b010;
    fwd_rd      = {5'd0, 5'd7, 5'd7};
    fwd_data    = {64'h0, 64'h99, 64'h77};
    #1;
    total++; if (hazard !== 1'b0) begin bad++; $display("FAIL hz_lowprio got=%0h exp=0", hazard); end
    fwd_pending = 3'b001;
    #1;
    total++; if (hazard !== 1'b1) begin bad++; $display("FAIL hz_set got=%0h exp=1", hazard); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hz_noacc1 got=%0h exp=0", out_valid); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hz_noacc2 got=%0h exp=0", out_valid); end
    total++; if (stall_cnt !== 32'd2) begin bad++; $display("FAIL hz_stall got=%0d exp=2", stall_cnt); end
    fwd_pending = 3'b000;
    step();
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hz_acc got=%0h exp=1", out_valid); end
    total++; if (out_rs1_data !== 64'h77) begin bad++; $display("FAIL hz_rs1 got=%0h exp=77", out_rs1_data); end
    total++; if (stall_cnt !== 32'd2) begin bad++; $display("FAIL hz_stall_hold got=%0d exp=2", stall_cnt); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    put(64'hA0, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2);
    step();
    total++; if (out_pc !== 64'hA0) begin bad++; $display("FAIL b2b_a got=%0h exp=a0", out_pc); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy1 got=%0h exp=1", in_ready); end
    put(64'hB0, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2);
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_rdy0 got=%0h exp=0", in_ready); end
    total++; if (out_pc !== 64'hA0) begin bad++; $display("FAIL b2b_hold1 got=%0h exp=a0", out_pc); end
    put(64'hC0, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2);
    step();
    total++; if (out_pc !== 64'hA0) begin bad++; $display("FAIL b2b_hold2 got=%0h exp=a0", out_pc); end
    total++; if (out_imm !== 64'hA4) begin bad++; $display("FAIL b2b_hold_imm got=%0h exp=a4", out_imm); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_rdy_held got=%0h exp=0", in_ready); end
    out_ready = 1'b1;
    step();
    total++; if (out_pc !== 64'hB0) begin bad++; $display("FAIL b2b_b got=%0h exp=b0", out_pc); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy_back got=%0h exp=1", in_ready); end
    step();
    idle();
    total++; if (out_pc !== 64'hC0) begin bad++; $display("FAIL b2b_c got=%0h exp=c0", out_pc); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_c_valid got=%0h exp=1", out_valid); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0h exp=0", out_valid); end
    total++; if (stall_cnt !== 32'd4) begin bad++; $display("FAIL b2b_stall got=%0d exp=4", stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    put(64'hD0, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2);
    step();
    put(64'hD8, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2);
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_full got=%0h exp=0", in_ready); end
    put(64'hE0, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2);
    flush = 1'b1;
    step();
    idle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%0h exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_ready got=%0h exp=1", in_ready); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_dropped got=%0h exp=0", out_valid); end
    total++; if (stall_cnt !== 32'd4) begin bad++; $display("FAIL fl_stall got=%0d exp=4", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    put(64'hF0, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2);
    step();
    put(64'hF8, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2);
    #2;
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%0h exp=0", out_valid); end
    total++; if (out_pc !== 64'h0) begin bad++; $display("FAIL rm_pc got=%0h exp=0", out_pc); end
    total++; if (stall_cnt !== 32'h0) begin bad++; $display("FAIL rm_stall got=%0h exp=0", stall_cnt); end
    put(64'h600, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2);
    reset     = 1'b1;
    out_ready = 1'b1;
    step();
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rm_lat got=%0h exp=1", out_valid); end
    total++; if (out_pc !== 64'h600) begin bad++; $display("FAIL rm_pc2 got=%0h exp=600", out_pc); end
    step();
  endtask

  task automatic test_saturate();
    put(64'h700, 5'd7, 5'd0, 5'd1, 64'h0, 64'h0);
    fwd_valid   = 3'b001;
    fwd_pending = 3'b001;
    fwd_rd      = {5'd0, 5'd0, 5'd7};
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    total++; if (stall_cnt !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sat_preset got=%0h exp=fffffffe", stall_cnt); end
    step();
    total++; if (stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_max got=%0h exp=ffffffff", stall_cnt); end
    step();
    step();
    total++; if (stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_nowrap got=%0h exp=ffffffff", stall_cnt); end
    idle();
    step();
  endtask

  initial begin
    idle();
    out_ready = 1'b1;
    reset     = 1'b0;
    test_reset();
    test_fwd_priority();
    test_x0();
    test_hazard();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_operand_stage.md
PIPELINE_OPERAND_STAGE -- requirements
Module: pipeline_operand_stage

Interface
REQ-001 Parameter XLEN, default 64, operand/PC/immediate width.
REQ-002 Parameter NFWD, default 3, number of forwarding sources; index 0 is highest priority (youngest producer).
REQ-003 Parameter CTRL_W, default 32, width of the opaque control bundle carried to EX/MEM/WB.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  synchronous kill of all held entries.
REQ-007 in_valid  in  1  upstream (IDC) entry present.
REQ-008 in_ready  out  1  stage can take an entry; registered, equals NOT skid_valid.
REQ-009 in_pc, in_imm  in  XLEN each  PC and decoded immediate.
REQ-010 in_rs1, in_rs2, in_rd  in  5 each  source/destination register indices.
REQ-011 in_ctrl  in  CTRL_W  control bundle, passed through unmodified.
REQ-012 rf_rdata1, rf_rdata2  in  XLEN each  register-file read data for in_rs1/in_rs2.
REQ-013 fwd_valid, fwd_pending  in  NFWD each  per-source: producer writes a register / its data not yet available.
REQ-014 fwd_rd  in  NFWD*5; fwd_data  in  NFWD*XLEN  per-source destination index and result.
REQ-015 out_valid  out  1; out_ready  in  1  downstream (EX) handshake.
REQ-016 out_pc, out_imm, out_rs1_data, out_rs2_data  out  XLEN each; out_rd  out  5; out_ctrl  out  CTRL_W.
REQ-017 hazard  out  1  combinational, load-use style stall indication.
REQ-018 stall_cnt  out  32  cycles in_valid was held off.

Function
REQ-019 Per operand: index 0 -> value 0; else lowest i with fwd_valid[i] and fwd_rd[i]==index -> fwd_data[i]; else rf_rdata.
REQ-020 hazard = in_valid AND (for rs1 or rs2, nonzero, the matching source selected per REQ-019 has fwd_pending set); lower-priority pending matches are ignored when a higher one matches.
REQ-021 accept = in_valid AND in_ready AND NOT hazard AND NOT flush.
REQ-022 Storage: main entry (drives out_*, out_valid=main_valid) plus one skid entry; resolved operands are captured at accept and never re-resolved while held.
REQ-023 pop = out_valid AND out_ready.
REQ-024 accept with main empty, or main popping with skid empty -> entry into main; out_valid next cycle (1-cycle latency).
REQ-025 accept with main valid and not popping -> entry into skid; in_ready drops next cycle.
REQ-026 pop with skid valid -> skid moves to main, skid_valid clears; no accept possible that cycle (in_ready=0).
REQ-027 pop with nothing accepted and skid empty -> main_valid clears.
REQ-028 Order preserved: skid entry always issues after main entry.
REQ-029 flush: next edge clears main_valid and skid_valid, same-cycle accept dropped, flush wins over all else; payload registers may retain stale data.
REQ-030 stall_cnt increments when in_valid AND NOT accept AND NOT flush; saturates at 0xFFFFFFFF; not cleared by flush.
REQ-031 out_* payload held stable while out_valid AND NOT out_ready.

Reset
REQ-032 reset low asynchronously: main_valid=0, skid_valid=0, in_ready=1, out_valid=0, all out_* payload=0, stall_cnt=0.
REQ-033 Reset asserted mid-operation discards held entries; first accept after release reaches out_valid exactly one cycle later.

Verification
REQ-034 rs1=5, rf=0x11, fwd0 rd=5 data=0xAA, fwd1 rd=5 data=0xBB, out_ready=1 -> next cycle out_valid=1, out_rs1_data=0xAA.
REQ-035 rs2=0, fwd0 valid rd=0 data=0xFF -> out_rs2_data=0.
REQ-036 rs1=7, fwd0 rd=7 pending=1 for 2 cycles, in_valid held -> hazard=1, no accept 2 cycles, stall_cnt=2; then accepted.
REQ-037 out_ready=0, three back-to-back in_valid -> first in main, second in skid, in_ready=0, third held; out_ready=1 -> entries emerge in order, one per cycle.
REQ-038 Main+skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing accepted.
REQ-039 stall_cnt preset near max (force 0xFFFFFFFE), 3 held cycles -> reads 0xFFFFFFFF, no wrap.
